// File: rtl/soc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// soc_mem_arbiter
//   Shares the single-port SoC memory between the core's instruction-fetch
//   master (i_*) and its data load/store master (d_*). One request at a time
//   is latched in IDLE and walked through ISSUE -> WAIT -> ACK -> IDLE.
//   Data normally wins arbitration; a starvation counter forces a fetch grant
//   after STARVE_LIMIT consecutive data grants while fetch was waiting.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   i_req/i_addr          fetch request (held until i_ack) and address
//   i_ack/i_rdata         one-cycle fetch completion pulse and its read data
//   d_req/d_we/d_addr     data request, write flag and address
//   d_wdata/d_be          data write data and byte enables
//   d_ack/d_rdata         one-cycle data completion pulse and its read data
//   mem_en/mem_we         memory strobe (one cycle per access) and write enable
//   mem_addr/mem_wdata    memory address and write data (latched request)
//   mem_be                memory byte enables
//   mem_rdata             memory read data, MEM_LATENCY cycles after mem_en
//   busy                  high whenever the arbiter is not in IDLE
// -----------------------------------------------------------------------------
module soc_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int BE_W = DATA_W / 8;

    // Down-counter preload: WAIT lasts MEM_LATENCY cycles, last one at count 0.
    localparam logic [2:0] WAIT_INIT  = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t         state_r;
    logic           owner_d_r;     // 1: latched request belongs to data master
    logic [2:0]     wait_cnt_r;
    logic [3:0]     starve_cnt_r;

    logic           starve_hit_s;
    logic           grant_d_s;
    logic           grant_i_s;

    // Arbitration decision for the current IDLE cycle.
    always_comb begin
        starve_hit_s = 1'b0;
        grant_d_s    = 1'b0;
        grant_i_s    = 1'b0;
        if (starve_cnt_r == STARVE_MAX) begin
            starve_hit_s = 1'b1;
        end else begin
            starve_hit_s = 1'b0;
        end
        // Fetch overrides data only when it has been passed over too often.
        if (d_req && !(i_req && starve_hit_s)) begin
            grant_d_s = 1'b1;
            grant_i_s = 1'b0;
        end else if (i_req) begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Transaction sequencer: latches the winner, drives the memory port and
    // returns a registered ack with the captured read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_d_r    <= 1'b0;
            wait_cnt_r   <= 3'd0;
            starve_cnt_r <= 4'd0;
            i_ack        <= 1'b0;
            i_rdata      <= {DATA_W{1'b0}};
            d_ack        <= 1'b0;
            d_rdata      <= {DATA_W{1'b0}};
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
            mem_be       <= {BE_W{1'b0}};
            busy         <= 1'b0;
        end else begin
            // Pulse-type outputs fall back to 0 unless a state sets them.
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= {DATA_W{1'b0}};
            d_rdata <= {DATA_W{1'b0}};
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (grant_d_s) begin
                        owner_d_r <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        busy      <= 1'b1;
                        state_r   <= ST_ISSUE;
                        // Count data grants that made a waiting fetch lose.
                        if (!i_req) begin
                            starve_cnt_r <= 4'd0;
                        end else if (starve_hit_s) begin
                            starve_cnt_r <= starve_cnt_r;
                        end else begin
                            starve_cnt_r <= starve_cnt_r + 4'd1;
                        end
                    end else if (grant_i_s) begin
                        owner_d_r    <= 1'b0;
                        mem_en       <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= i_addr;
                        mem_wdata    <= {DATA_W{1'b0}};
                        mem_be       <= {BE_W{1'b1}};
                        busy         <= 1'b1;
                        state_r      <= ST_ISSUE;
                        starve_cnt_r <= 4'd0;
                    end else begin
                        // No request at all implies i_req=0.
                        starve_cnt_r <= 4'd0;
                        state_r      <= ST_IDLE;
                    end
                end

                ST_ISSUE: begin
                    wait_cnt_r <= WAIT_INIT;
                    state_r    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_cnt_r == 3'd0) begin
                        // mem_rdata is valid now; capture it straight into the
                        // owner's registered read-data output for the ACK cycle.
                        state_r <= ST_ACK;
                        if (owner_d_r) begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 3'd1;
                    end
                end

                ST_ACK: begin
                    // Requests are deliberately not sampled here so a master
                    // still holding req during its ack is not served twice.
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter: one instance with MEM_LATENCY=1 drives
// most scenarios, a second with MEM_LATENCY=3 covers the longer fetch path.
module tb_soc_mem_arbiter;

    logic clk;
    logic reset;

    // Instance with MEM_LATENCY = 1
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        i_ack, d_ack, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    // Instance with MEM_LATENCY = 3 (fetch only)
    logic        i3_req;
    logic [31:0] i3_addr;
    logic        z_bit;
    logic [31:0] z_word;
    logic [3:0]  z_be;
    logic        i3_ack, d3_ack, m3_en, m3_we, busy3;
    logic [31:0] i3_rdata, d3_rdata, m3_addr, m3_wdata, m3_rdata;
    logic [3:0]  m3_be;

    int n_checks;
    int n_fail;

    logic        snap_en, snap_we, snap_busy;
    logic [31:0] snap_addr, snap_wdata, snap_rd;
    logic [3:0]  snap_be;
    int          other_acks;

    soc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    soc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .i_req(i3_req), .i_addr(i3_addr), .i_ack(i3_ack), .i_rdata(i3_rdata),
        .d_req(z_bit), .d_we(z_bit), .d_addr(z_word), .d_wdata(z_word), .d_be(z_be),
        .d_ack(d3_ack), .d_rdata(d3_rdata),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_be(m3_be), .mem_rdata(m3_rdata), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model, latency 1: word 0x20 preloaded, everything else zero.
    logic [31:0] mem1 [0:63];
    logic [31:0] rd1;
    assign mem_rdata = rd1;

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 64; k++) mem1[k] <= 32'h0;
            mem1[8] <= 32'h1234_5678;
            rd1     <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem1[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                rd1 <= mem1[mem_addr[7:2]];
            end
        end
    end

    // Memory model, latency 3: read-only pattern through a 3-stage pipe.
    logic [31:0] s3a, s3b, s3c;
    assign m3_rdata = s3c;

    always @(posedge clk) begin
        s3a <= m3_en ? ((m3_addr == 32'h20) ? 32'h1234_5678 : (32'hBAD0_0000 | m3_addr)) : 32'h0;
        s3b <= s3a;
        s3c <= s3b;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call right after a rising edge (+#1). Cycle 0 is the cycle the request
    // is first visible; returns the cycle of the owner's ack (-1 if none).
    task automatic txn(input logic is_d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output int ack_cyc, output logic [31:0] rdata);
        ack_cyc    = -1;
        rdata      = 32'h0;
        other_acks = 0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                snap_en = mem_en; snap_we = mem_we; snap_addr = mem_addr;
                snap_wdata = mem_wdata; snap_be = mem_be; snap_busy = busy;
                snap_rd = d_rdata | i_rdata;
            end
            if (is_d ? i_ack : d_ack) other_acks++;
            if (is_d ? d_ack : i_ack) begin
                ack_cyc = c;
                rdata   = is_d ? d_rdata : i_rdata;
                break;
            end
        end
        d_req = 1'b0;
        i_req = 1'b0;
        @(posedge clk); #1;
    endtask

    int          cyc, cyc_d, cyc_i, n_acks, cnt;
    logic [31:0] rd;
    logic [9:0]  order;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        i3_req = 1'b0; i3_addr = 32'h0;
        z_bit = 1'b0; z_word = 32'h0; z_be = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_acks", {i_ack, d_ack}, 2'b00);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rdata", d_rdata | i_rdata, 32'h0);
        @(posedge clk); #1;

        // Data write, latency 1
        txn(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011, cyc, rd);
        chk("wr_mem_en", snap_en, 1'b1);
        chk("wr_mem_we", snap_we, 1'b1);
        chk("wr_mem_addr", snap_addr, 32'h10);
        chk("wr_mem_wdata", snap_wdata, 32'hDEAD_BEEF);
        chk("wr_mem_be", snap_be, 4'b0011);
        chk("wr_busy", snap_busy, 1'b1);
        chk("wr_ack_cycle", cyc, 3);
        chk("wr_no_i_ack", other_acks, 0);

        // Read back: only the low two bytes were enabled
        txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, cyc, rd);
        chk("rd10_ack_cycle", cyc, 3);
        chk("rd10_data", rd, 32'h0000_BEEF);
        chk("rd10_we", snap_we, 1'b0);

        // Fetch, latency 1
        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, cyc, rd);
        chk("if1_ack_cycle", cyc, 3);
        chk("if1_data", rd, 32'h1234_5678);
        chk("if1_mem_we", snap_we, 1'b0);
        chk("if1_mem_be", snap_be, 4'hF);
        chk("if1_mem_wdata", snap_wdata, 32'h0);
        chk("if1_rdata_idle", snap_rd, 32'h0);
        chk("if1_no_d_ack", other_acks, 0);

        // Fetch, latency 3
        i3_req = 1'b1; i3_addr = 32'h20;
        cyc = -1; rd = 32'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (i3_ack) begin cyc = c; rd = i3_rdata; break; end
        end
        i3_req = 1'b0;
        @(posedge clk); #1;
        chk("if3_ack_cycle", cyc, 5);
        chk("if3_data", rd, 32'h1234_5678);

        // Starvation guard with both masters requesting continuously
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_be = 4'hF;
        n_acks = 0; order = 10'b0;
        for (int c = 0; c < 120 && n_acks < 10; c++) begin
            @(negedge clk);
            if (d_ack || i_ack) begin
                order[n_acks] = i_ack;
                n_acks++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        chk("starve_acks", n_acks, 10);
        chk("starve_order", order, 10'b10_0001_0000);

        // Simultaneous requests with an empty starve counter
        repeat (2) @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        cyc_d = -1; cyc_i = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (d_ack) begin cyc_d = c; d_req = 1'b0; end
            if (i_ack) begin cyc_i = c; i_req = 1'b0; break; end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        chk("simul_d_first", cyc_d, 3);
        chk("simul_i_gap", cyc_i - cyc_d, 4);

        // Master changes addr/data right after grant
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hA5A5_A5A5; d_be = 4'hF;
        @(posedge clk); #1;
        d_addr = 32'h34; d_wdata = 32'h1111_1111; d_be = 4'h0;
        @(negedge clk);
        chk("latch_mem_addr", mem_addr, 32'h30);
        chk("latch_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("latch_mem_be", mem_be, 4'hF);
        cyc = -1;
        for (int c = 2; c < 20; c++) begin
            @(negedge clk);
            if (d_ack) begin cyc = c; break; end
        end
        d_req = 1'b0;
        @(posedge clk); #1;
        chk("latch_ack_cycle", cyc, 3);
        txn(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, cyc, rd);
        chk("latch_rd30", rd, 32'hA5A5_A5A5);
        txn(1'b1, 1'b0, 32'h34, 32'h0, 4'hF, cyc, rd);
        chk("latch_rd34", rd, 32'h0);

        // Fetch request dropped after grant still completes once
        i_req = 1'b1; i_addr = 32'h20;
        @(posedge clk); #1;
        i_req = 1'b0;
        cnt = 0; cyc = -1;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (i_ack) begin cnt++; cyc = c; end
        end
        @(posedge clk); #1;
        chk("drop_ack_cycle", cyc, 3);
        chk("drop_ack_count", cnt, 1);

        // Reset in the middle of WAIT
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_be = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_outs", {mem_en, mem_we, i_ack, d_ack}, 4'b0000);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_ack || i_ack) cnt++;
        end
        @(posedge clk); #1;
        chk("midrst_no_ack", cnt, 0);
        txn(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, cyc, rd);
        chk("midrst_fresh_cycle", cyc, 3);
        chk("midrst_fresh_data", rd, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
